compare_sort_ctrl: RTL and testbench

Sequential sorting controller that time-shares one `comparator_16bit` instance to sort a buffer of DEPTH unsigned 16-bit words in ascending order.
- Accepts DEPTH words over a valid/ready input.
- Bubble-sorts them in place, one compare-and-swap per cycle.
- Streams the sorted words out over a valid/ready output.
- Sits between the operand capture logic and any downstream consumer that needs ordered data.

---
 rtl/compare_sort_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_compare_sort_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/compare_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : compare_sort_ctrl (with helper comparator_16bit)
// Summary  : Loads DEPTH words, sorts them ascending in place with bubble sort
//            (one compare-and-swap per cycle), then streams them out.
//            Optional macro SORT_EARLY_EXIT_EN stops after a swap-free pass.
// Revision : 1.0 - initial release
// ============================================================================

module comparator_16bit (
  input  logic [15:0] ain,
  input  logic [15:0] bin,
  output logic        greater,
  output logic        equal,
  output logic        less
);
  assign greater = ain > bin;
  assign equal   = ain == bin;
  assign less    = ain < bin;
endmodule

module compare_sort_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        sort_done,
  output logic [7:0]  swap_count
);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 2);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [15:0]     mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic [7:0]      swap_count_q, swap_count_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     out_data_q, out_data_d;
  logic            busy_q, busy_d;
  logic            sort_done_q, sort_done_d;
  logic            swapped_q, swapped_d;

  logic [PW-1:0]   idx_p1;
  logic            greater, equal, less;
  logic            unused_cmp;
  logic            pass_end;
  logic            sort_finish;

  assign idx_p1 = idx_q + 1'b1;

  comparator_16bit u_cmp (
    .ain     (mem_q[idx_q]),
    .bin     (mem_q[idx_p1]),
    .greater (greater),
    .equal   (equal),
    .less    (less)
  );

  // Only 'greater' drives a swap; ties stay put, which keeps the sort stable.
  assign unused_cmp = equal | less;
  assign pass_end   = (idx_q == LAST_IDX - pass_q);

`ifdef SORT_EARLY_EXIT_EN
  assign sort_finish = (pass_q == LAST_IDX) || !(swapped_q || greater);
`else
  assign sort_finish = (pass_q == LAST_IDX);
`endif

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    idx_d        = idx_q;
    pass_d       = pass_q;
    swap_count_d = swap_count_q;
    swapped_d    = swapped_q;

    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          mem_d[wr_ptr_q] = in_data;
          wr_ptr_d        = wr_ptr_q + 1'b1;
          if (wr_ptr_q == '0) swap_count_d = 8'd0;
          if (wr_ptr_q == LAST_PTR) begin
            state_d   = S_SORT;
            wr_ptr_d  = '0;
            idx_d     = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
          end
        end
      end
      S_SORT: begin
        if (greater) begin
          mem_d[idx_q]  = mem_q[idx_p1];
          mem_d[idx_p1] = mem_q[idx_q];
          swap_count_d  = swap_count_q + 8'd1;
          swapped_d     = 1'b1;
        end
        if (pass_end) begin
          idx_d     = '0;
          pass_d    = pass_q + 1'b1;
          swapped_d = 1'b0;
          if (sort_finish) begin
            state_d  = S_DRAIN;
            rd_ptr_d = '0;
          end
        end else begin
          idx_d = idx_p1;
        end
      end
      S_DRAIN: begin
        if (out_ready && out_valid_q) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == LAST_PTR) begin
            state_d  = S_LOAD;
            rd_ptr_d = '0;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    // Outputs are registered from the next-state view so they line up with state_q.
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_DRAIN);
    busy_d      = (state_d == S_SORT);
    sort_done_d = (state_q == S_SORT) && (state_d == S_DRAIN);
    out_data_d  = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= 16'h0000;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      idx_q        <= '0;
      pass_q       <= '0;
      swap_count_q <= 8'd0;
      swapped_q    <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= 16'h0000;
      busy_q       <= 1'b0;
      sort_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      idx_q        <= idx_d;
      pass_q       <= pass_d;
      swap_count_q <= swap_count_d;
      swapped_q    <= swapped_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      sort_done_q  <= sort_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign sort_done  = sort_done_q;
  assign swap_count = swap_count_q;

endmodule
`default_nettype wire

// File: tb/tb_compare_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_compare_sort_ctrl
// Summary  : Directed table-driven bench for compare_sort_ctrl (DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_compare_sort_ctrl;
  localparam int DEPTH = 8;

`ifdef SORT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    logic [0:7][15:0] din;
    logic [0:7][15:0] dout;
    int               swaps;
    int               lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy, sort_done;
  logic [15:0] out_data;
  logic [7:0]  swap_count;

  int n_cmp = 0;
  int n_bad = 0;

  compare_sort_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .sort_done  (sort_done),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_batch(input logic [0:7][15:0] d);
    for (int k = 0; k < DEPTH; k++) begin
      chk("in_ready_load", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = d[k];
      @(posedge clk); #1;
      if (k == 0) chk("swap_count_clear", {24'd0, swap_count}, 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_sorted(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      in_valid = lat[0];
      in_data  = 16'hDEAD;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic [0:7][15:0] exp, input int stall_at);
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_data", {16'd0, out_data}, {16'd0, exp[k]});
        end
        out_ready = 1'b1;
      end
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk($sformatf("out_data[%0d]", k), {16'd0, out_data}, {16'd0, exp[k]});
      in_valid = (k < DEPTH - 1) && k[0];
      in_data  = 16'hBEEF;
      @(posedge clk); #1;
      if (k == 0) chk("sort_done_pulse", {31'd0, sort_done}, 32'd0);
    end
    in_valid = 1'b0;
    chk("valid_after_drain", {31'd0, out_valid}, 32'd0);
    chk("ready_after_drain", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int stall_at);
    int lat;
    load_batch(v.din);
    chk("busy_in_sort", {31'd0, busy}, 32'd1);
    chk("no_ready_in_sort", {31'd0, in_ready}, 32'd0);
    wait_sorted(lat);
    chk("sort_latency", lat, v.lat);
    chk("sort_done", {31'd0, sort_done}, 32'd1);
    chk("busy_in_drain", {31'd0, busy}, 32'd0);
    chk("swap_count", {24'd0, swap_count}, v.swaps);
    drain(v.dout, stall_at);
    chk("swap_count_hold", {24'd0, swap_count}, v.swaps);
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0].din  = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    vecs[0].dout = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    vecs[0].swaps = 28; vecs[0].lat = 28;
    vecs[1].din  = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    vecs[1].dout = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    vecs[1].swaps = 0;  vecs[1].lat = EE ? 7 : 28;
    vecs[2].din  = {16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h0000};
    vecs[2].dout = {16'h0000, 16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF};
    vecs[2].swaps = 15; vecs[2].lat = 28;
    vecs[3].din  = {16'h0003, 16'h0005, 16'h0005, 16'h0100, 16'h0200, 16'h0300, 16'hA000, 16'h9000};
    vecs[3].dout = {16'h0003, 16'h0005, 16'h0005, 16'h0100, 16'h0200, 16'h0300, 16'h9000, 16'hA000};
    vecs[3].swaps = 1;  vecs[3].lat = EE ? 13 : 28;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sort_done", {31'd0, sort_done}, 32'd0);
    chk("rst_swap_count", {24'd0, swap_count}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;

    // Batches run back to back: each load starts the cycle after the previous drain.
    for (int n = 0; n < 4; n++) run_vec(vecs[n], (n == 2) ? 3 : -1);

    // Reset in the middle of sorting a reversed batch.
    load_batch(vecs[0].din);
    repeat (10) @(posedge clk);
    #1;
    chk("midsort_swaps", {24'd0, swap_count}, 32'd10);
    chk("midsort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_swap_count", {24'd0, swap_count}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[2], -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
